display_capture_writer: RTL and testbench
=========================================

Name: display_capture_writer

Overview:
- Producer side of the two dual-port display RAMs consumed by the image controller; drives their port A (ck100MHz domain).
- Time path:
  - captures a triggered window of 640 audio samples;
  - scales and clamps each sample to the signed display range;
  - writes address 0..639 of the time RAM.
- Frequency path:
  - compresses an FFT magnitude stream to 8-bit bar heights;
  - writes the first FREQ_BINS bins of the frequency RAM.

Parameters:
- TIME_LEN, 640: samples written per capture (time RAM addresses 0..TIME_LEN-1).
- DECIM, 1: keep every DECIM-th valid time sample during capture (1 = keep all).
- TIME_SHIFT, 8: arithmetic right shift applied to the 16-bit time sample.
- TIME_CLAMP, 119: symmetric clamp of the shifted time sample to -TIME_CLAMP..+TIME_CLAMP.
- TRIG_HYST, 64: rising-edge trigger hysteresis, in raw 16-bit units.
- TRIG_TIMEOUT, 4096: valid samples waited in TRIG before a forced capture.
- HOLDOFF, 1000000: ck100MHz cycles idle after a capture (10 ms).
- FREQ_SHIFT, 4: logical right shift applied to the 16-bit magnitude.
- FREQ_MAX, 230: saturation ceiling of the frequency bar height.
- FREQ_BINS, 128: bins written per FFT frame; higher bins are dropped.

Ports:
- ck100MHz  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- enable  in  1  when low, no new capture or frame is started (display freeze).
- timeSample  in  16  signed audio sample.
- timeValid  in  1  one-cycle strobe qualifying timeSample.
- fftMag  in  16  unsigned FFT magnitude.
- fftValid  in  1  magnitude beat valid.
- fftLast  in  1  last beat of an FFT frame (qualified by fftValid).
- enaTime  out  1  time RAM port-A enable.
- weaTime  out  1  time RAM write enable.
- addraTime  out  10  time RAM write address.
- dinaTime  out  8  time RAM write data (two's complement).
- weaFreq  out  1  frequency RAM write enable.
- addraFreq  out  10  frequency RAM write address.
- dinaFreq  out  8  frequency RAM write data.
- captureDone  out  1  one-cycle pulse after the final time write of a capture.
- busy  out  1  high in states TRIG, CAPT and HOLD.

Behaviour:
- Reset:
  - All outputs 0.
  - Time FSM in IDLE; all counters 0; prevSample 0; freq bin counter 0; freq path in "waiting for frame start".
- Time FSM states: IDLE, TRIG, CAPT, HOLD.
  - IDLE: go to TRIG when enable=1.
  - TRIG, per valid sample:
    - The trigger is armed once a sample is below -TRIG_HYST.
    - If armed and the sample is >= 0: trigger, go to CAPT. The triggering sample is the first one written.
    - The timeout counter increments on each valid sample. At TRIG_TIMEOUT it forces CAPT, and the next valid sample becomes the first one written.
  - CAPT:
    - A decimation counter selects every DECIM-th valid sample.
    - Each selected sample is shifted, clamped, then written at addr = write index; the index starts at 0.
    - After the write at index TIME_LEN-1: pulse captureDone, go to HOLD.
  - HOLD: count HOLDOFF cycles, then go to IDLE. enable is not sampled in HOLD.
- Time write timing:
  - Write happens the cycle after the accepted timeValid (one register stage).
  - enaTime = weaTime = 1 for exactly that cycle; otherwise both are 0.
  - addraTime and dinaTime are held between writes.
- Time scaling:
  - s = timeSample >>> TIME_SHIFT (arithmetic).
  - dinaTime = min(max(s, -TIME_CLAMP), TIME_CLAMP), in 8-bit two's complement.
  - Purpose: the reader's 120-minus-sample height stays inside the top half.
- enable falling in TRIG or CAPT: the current capture completes normally; no new capture starts.
- Frequency path:
  - A frame is accepted only if enable=1 on its first beat (the first beat after reset or after fftLast). A rejected frame is discarded through its fftLast.
  - Bin counter increments on each valid beat and resets to 0 after fftLast.
  - Write when bin < FREQ_BINS, one cycle after the beat:
    - weaFreq = 1;
    - addraFreq = bin;
    - dinaFreq = min(fftMag >> FREQ_SHIFT, FREQ_MAX).
  - Bins >= FREQ_BINS produce no write.
  - fftValid with fftLast on bin 0: single-beat frame, one write.
- Independence: the time and frequency paths may write in the same cycle.
- Reset mid-capture: immediate return to IDLE, no write pulse, partial RAM contents left as-is.

Decomposition:
- Shared package display_pkg:
  - display geometry constants (active width 640, half-height 240, freq baseline 470);
  - time FSM state enum;
  - default TIME_CLAMP and FREQ_MAX values.
- One natural sub-module, sat_scale: parameterised shift plus saturation. Instantiated signed for the time path and unsigned for the frequency path.

Test Plan:
- Reset release with enable=1, sine ±20000 raw → trigger on the first crossing at >= 0 after < -64. Expect 640 weaTime pulses at addresses 0..639, then one captureDone pulse, then no writes for 1000000 cycles.
- timeSample = +32767 → dinaTime = 119 (0x77). timeSample = -32768 → dinaTime = -119 (0x89). timeSample = 0x1A00 → dinaTime = 26.
- Constant input 100 with enable=1 → forced capture after 4096 valid samples. Every write carries dinaTime = 0.
- FFT frame of 256 beats, mag = bin*40 → 128 weaFreq writes only. Expect bin 5 → 12, and bin 100 → 230 (saturated, since 4000>>4 = 250).
- enable dropped at write index 300 → capture completes to 639 and pulses captureDone. Return to IDLE after HOLD with no further TRIG. An FFT frame starting while enable=0 produces zero weaFreq.
- resetN asserted at write index 200 → all outputs 0 the same cycle; after release the next capture restarts at address 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display geometry, capture FSM state encoding and default scaling limits
// for the writer that fills the time and frequency display RAMs.
package display_pkg;
    localparam int unsigned ACTIVE_W       = 640;
    localparam int unsigned HALF_H         = 240;
    localparam int unsigned FREQ_BASELINE  = 470;
    localparam int unsigned DEF_TIME_CLAMP = 119;
    localparam int unsigned DEF_FREQ_MAX   = 230;
    localparam int unsigned RAM_AW         = 10;
    localparam int unsigned PIX_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_CAPT = 2'd2,
        ST_HOLD = 2'd3
    } time_state_t;
endpackage

// File: rtl/sat_scale.sv
// Right shift (arithmetic when SIGNED, logical otherwise) followed by saturation
// to [-MAX, +MAX] (signed) or [0, MAX] (unsigned); purely combinational.
module sat_scale #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SHIFT  = 8,
    parameter int unsigned MAX    = 119,
    parameter bit          SIGNED = 1'b1
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_data_c
);
    localparam int unsigned EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] HI = EXT_W'(MAX);
    localparam logic signed [EXT_W-1:0] LO = SIGNED ? -HI : '0;

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_shr;

    // One extra bit lets signed and unsigned inputs share a single signed compare.
    always_comb begin
        w_ext = SIGNED ? $signed({i_data[IN_W-1], i_data}) : $signed({1'b0, i_data});
        w_shr = w_ext >>> SHIFT;
        if (w_shr > HI) begin
            o_data_c = OUT_W'(HI);
        end else if (w_shr < LO) begin
            o_data_c = OUT_W'(LO);
        end else begin
            o_data_c = OUT_W'(w_shr);
        end
    end
endmodule

// File: rtl/display_capture_writer.sv
// Port-A producer for the time and frequency display RAMs: triggered time-window
// capture with scale/clamp, and FFT magnitude compression into bar heights.
module display_capture_writer
    import display_pkg::*;
#(
    parameter int unsigned TIME_LEN     = ACTIVE_W,
    parameter int unsigned DECIM        = 1,
    parameter int unsigned TIME_SHIFT   = 8,
    parameter int unsigned TIME_CLAMP   = DEF_TIME_CLAMP,
    parameter int unsigned TRIG_HYST    = 64,
    parameter int unsigned TRIG_TIMEOUT = 4096,
    parameter int unsigned HOLDOFF      = 1000000,
    parameter int unsigned FREQ_SHIFT   = 4,
    parameter int unsigned FREQ_MAX     = DEF_FREQ_MAX,
    parameter int unsigned FREQ_BINS    = 128
) (
    input  logic              ck100MHz,
    input  logic              resetN,
    input  logic              enable,
    input  logic [15:0]       timeSample,
    input  logic              timeValid,
    input  logic [15:0]       fftMag,
    input  logic              fftValid,
    input  logic              fftLast,
    output logic              enaTime,
    output logic              weaTime,
    output logic [RAM_AW-1:0] addraTime,
    output logic [PIX_W-1:0]  dinaTime,
    output logic              weaFreq,
    output logic [RAM_AW-1:0] addraFreq,
    output logic [PIX_W-1:0]  dinaFreq,
    output logic              captureDone,
    output logic              busy
);
    localparam int unsigned TO_W  = $clog2(TRIG_TIMEOUT + 1);
    localparam int unsigned HO_W  = $clog2(HOLDOFF + 1);
    localparam int unsigned DEC_W = $clog2(DECIM + 1);
    localparam int unsigned BIN_W = $clog2(FREQ_BINS + 1);
    localparam int          ARM_LVL  = -int'(TRIG_HYST);
    localparam logic [RAM_AW-1:0] LAST_IDX = RAM_AW'(TIME_LEN - 1);

    time_state_t       r_state, w_state_next;
    logic              r_armed;
    logic [TO_W-1:0]   r_to_cnt;
    logic [HO_W-1:0]   r_hold_cnt;
    logic [DEC_W-1:0]  r_dec_cnt, w_dec_next;
    logic [RAM_AW-1:0] r_idx;
    logic              r_wr_t, r_done, r_busy;
    logic [RAM_AW-1:0] r_addr_t;
    logic [PIX_W-1:0]  r_din_t;
    logic              w_write, w_last, w_arm;
    logic [PIX_W-1:0]  w_time_scaled, w_freq_scaled;

    logic              r_wait_start, r_frame_ok, r_wr_f;
    logic [BIN_W-1:0]  r_bin;
    logic [RAM_AW-1:0] r_addr_f;
    logic [PIX_W-1:0]  r_din_f;
    logic              w_beat_ok;

    sat_scale #(.IN_W(16), .OUT_W(PIX_W), .SHIFT(TIME_SHIFT), .MAX(TIME_CLAMP), .SIGNED(1'b1))
        u_time_scale (.i_data(timeSample), .o_data_c(w_time_scaled));

    sat_scale #(.IN_W(16), .OUT_W(PIX_W), .SHIFT(FREQ_SHIFT), .MAX(FREQ_MAX), .SIGNED(1'b0))
        u_freq_scale (.i_data(fftMag), .o_data_c(w_freq_scaled));

    always_ff @(posedge ck100MHz or negedge resetN) begin
        if (!resetN) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Trigger, capture and hold sequencing; w_write marks an accepted sample.
    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_last       = (r_idx == LAST_IDX);
        w_arm        = timeValid && (int'($signed(timeSample)) < ARM_LVL);
        w_dec_next   = (r_dec_cnt == DEC_W'(DECIM - 1)) ? '0 : r_dec_cnt + DEC_W'(1);
        unique case (r_state)
            ST_IDLE: if (enable) w_state_next = ST_TRIG;
            ST_TRIG: begin
                if (timeValid) begin
                    if (r_armed && !timeSample[15]) begin
                        w_write      = 1'b1;
                        w_state_next = w_last ? ST_HOLD : ST_CAPT;
                    end else if (r_to_cnt == TO_W'(TRIG_TIMEOUT - 1)) begin
                        w_state_next = ST_CAPT;
                    end
                end
            end
            ST_CAPT: begin
                if (timeValid && (r_dec_cnt == '0)) begin
                    w_write = 1'b1;
                    if (w_last) w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: if (r_hold_cnt == HO_W'(HOLDOFF - 1)) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck100MHz or negedge resetN) begin
        if (!resetN) begin
            r_armed    <= 1'b0;
            r_to_cnt   <= '0;
            r_hold_cnt <= '0;
            r_dec_cnt  <= '0;
            r_idx      <= '0;
            r_wr_t     <= 1'b0;
            r_addr_t   <= '0;
            r_din_t    <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_armed    <= (r_state == ST_TRIG) && (r_armed || w_arm);
            r_to_cnt   <= (r_state != ST_TRIG) ? '0 : (timeValid ? r_to_cnt + TO_W'(1) : r_to_cnt);
            r_hold_cnt <= (r_state == ST_HOLD) ? r_hold_cnt + HO_W'(1) : '0;
            if (r_state == ST_TRIG || r_state == ST_CAPT) begin
                if (timeValid && (r_state == ST_CAPT || w_write)) r_dec_cnt <= w_dec_next;
            end else begin
                r_dec_cnt <= '0;
            end
            if (r_state == ST_IDLE) r_idx <= '0;
            else if (w_write)       r_idx <= r_idx + RAM_AW'(1);
            r_wr_t <= w_write;
            if (w_write) begin
                r_addr_t <= r_idx;
                r_din_t  <= w_time_scaled;
            end
            r_done <= r_wr_t && (r_addr_t == LAST_IDX);
            r_busy <= (w_state_next != ST_IDLE);
        end
    end

    // A frame's fate is decided by enable on its first beat and kept until fftLast.
    assign w_beat_ok = r_wait_start ? enable : r_frame_ok;

    always_ff @(posedge ck100MHz or negedge resetN) begin
        if (!resetN) begin
            r_wait_start <= 1'b1;
            r_frame_ok   <= 1'b0;
            r_bin        <= '0;
            r_wr_f       <= 1'b0;
            r_addr_f     <= '0;
            r_din_f      <= '0;
        end else begin
            r_wr_f <= 1'b0;
            if (fftValid) begin
                if (r_wait_start) r_frame_ok <= enable;
                r_wait_start <= fftLast;
                if (fftLast)                          r_bin <= '0;
                else if (r_bin != BIN_W'(FREQ_BINS)) r_bin <= r_bin + BIN_W'(1);
                if (w_beat_ok && (r_bin < BIN_W'(FREQ_BINS))) begin
                    r_wr_f   <= 1'b1;
                    r_addr_f <= RAM_AW'(r_bin);
                    r_din_f  <= w_freq_scaled;
                end
            end
        end
    end

    assign enaTime     = r_wr_t;
    assign weaTime     = r_wr_t;
    assign addraTime   = r_addr_t;
    assign dinaTime    = r_din_t;
    assign weaFreq     = r_wr_f;
    assign addraFreq   = r_addr_f;
    assign dinaFreq    = r_din_f;
    assign captureDone = r_done;
    assign busy        = r_busy;
endmodule

// File: tb/tb_display_capture_writer.sv
// Self-checking bench for display_capture_writer: scaling tables, triggered and
// forced captures, enable freeze, mid-capture reset and FFT frame compression.
`timescale 1ns/1ps
module tb_display_capture_writer;
    localparam int HOLDOFF_TB = 300;
    localparam int TLEN       = 640;
    localparam int TIMEOUT    = 4096;
    localparam int NBINS      = 128;

    logic        clk = 1'b0, resetN = 1'b0, enable = 1'b0;
    logic        timeValid = 1'b0, fftValid = 1'b0, fftLast = 1'b0;
    logic [15:0] timeSample = '0, fftMag = '0;
    logic        enaTime, weaTime, weaFreq, captureDone, busy;
    logic [9:0]  addraTime, addraFreq;
    logic [7:0]  dinaTime, dinaFreq;

    display_capture_writer #(.HOLDOFF(HOLDOFF_TB)) dut (
        .ck100MHz(clk), .resetN(resetN), .enable(enable),
        .timeSample(timeSample), .timeValid(timeValid),
        .fftMag(fftMag), .fftValid(fftValid), .fftLast(fftLast),
        .enaTime(enaTime), .weaTime(weaTime), .addraTime(addraTime), .dinaTime(dinaTime),
        .weaFreq(weaFreq), .addraFreq(addraFreq), .dinaFreq(dinaFreq),
        .captureDone(captureDone), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int s; int exp; } tv_t;
    typedef struct { int bin; int exp; } fv_t;

    wr_t  tq[$];
    wr_t  fq[$];
    tv_t  ttab[14];
    fv_t  ftab[7];
    int   cyc = 0, done_cnt = 0, done_cyc = -1, last_wt_cyc = -1, ena_bad = 0, busy_fall_cyc = -1;
    logic prev_busy = 1'b0;
    int   n_checks = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (weaTime) begin
            tq.push_back('{int'(addraTime), int'($signed(dinaTime)), cyc});
            last_wt_cyc = cyc;
        end
        if (weaFreq) fq.push_back('{int'(addraFreq), int'(dinaFreq), cyc});
        if (enaTime !== weaTime) ena_bad++;
        if (captureDone) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference scaling from the arithmetic definition: floor divide then clamp.
    function automatic int time_model(input int s);
        int q;
        q = s / 256;
        if (s < 0 && (s % 256) != 0) q = q - 1;
        if (q > 119) q = 119;
        if (q < -119) q = -119;
        return q;
    endfunction

    function automatic int freq_model(input int m);
        int q;
        q = m / 16;
        return (q > 230) ? 230 : q;
    endfunction

    // Index of the first stimulus sample that lands at address 0.
    function automatic int find_first(input int q[$]);
        bit armed = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (armed && q[i] >= 0) return i;
            if (q[i] < -64) armed = 1'b1;
            if (i + 1 == TIMEOUT) return i + 1;
        end
        return -1;
    endfunction

    function automatic int sine(input int n);
        return int'(20000.0 * $sin(6.283185307 * n / 50.0));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input int s);
        timeSample = 16'(s);
        timeValid  = 1'b1;
        @(posedge clk); #1;
        timeValid  = 1'b0;
    endtask

    task automatic fft_beat(input int m, input bit last);
        fftMag   = 16'(m);
        fftValid = 1'b1;
        fftLast  = last;
        @(posedge clk); #1;
        fftValid = 1'b0;
        fftLast  = 1'b0;
    endtask

    task automatic fresh_start();
        enable = 1'b0;
        resetN = 1'b0;
        tick(2);
        resetN = 1'b1;
        tq.delete();
        fq.delete();
        done_cnt = 0; done_cyc = -1; busy_fall_cyc = -1;
        enable = 1'b1;
        tick(3);
    endtask

    task automatic check_capture(input string tag, input int stim[$], input int first);
        int aerr = 0, derr = 0;
        check({tag, "_write_count"}, tq.size(), TLEN);
        for (int i = 0; i < tq.size() && i < TLEN; i++) begin
            if (tq[i].addr != i) aerr++;
            if (first < 0 || first + i >= stim.size()) derr++;
            else if (tq[i].data != time_model(stim[first + i])) derr++;
        end
        check({tag, "_addr_errors"}, aerr, 0);
        check({tag, "_data_errors"}, derr, 0);
    endtask

    task automatic check_freq(input string tag, input int mags[$]);
        int aerr = 0, derr = 0, nexp;
        nexp = (mags.size() < NBINS) ? mags.size() : NBINS;
        check({tag, "_write_count"}, fq.size(), nexp);
        for (int i = 0; i < fq.size() && i < nexp; i++) begin
            if (fq[i].addr != i) aerr++;
            if (fq[i].data != freq_model(mags[i])) derr++;
        end
        check({tag, "_addr_errors"}, aerr, 0);
        check({tag, "_data_errors"}, derr, 0);
    endtask

    initial begin
        int   stim[$];
        int   mags[$];
        int   first, hold_w, post_w;
        bit   did_rst;
        wr_t  w;
        logic [15:0] r16;

        ttab = '{'{32767, 119}, '{-32768, -119}, '{6656, 26}, '{0, 0}, '{-256, -1},
                 '{-1, -1}, '{255, 0}, '{30464, 119}, '{30208, 118}, '{-30464, -119},
                 '{-30209, -119}, '{-30208, -118}, '{30720, 119}, '{-30720, -119}};
        ftab = '{'{0, 0}, '{5, 12}, '{57, 142}, '{91, 227}, '{92, 230}, '{100, 230}, '{127, 230}};

        // Reset state
        tick(3);
        check("rst_weaTime", int'(weaTime), 0);
        check("rst_enaTime", int'(enaTime), 0);
        check("rst_addraTime", int'(addraTime), 0);
        check("rst_dinaTime", int'(dinaTime), 0);
        check("rst_weaFreq", int'(weaFreq), 0);
        check("rst_addraFreq", int'(addraFreq), 0);
        check("rst_captureDone", int'(captureDone), 0);
        check("rst_busy", int'(busy), 0);

        // Sine trigger, full capture, then holdoff
        resetN = 1'b1; enable = 1'b1;
        tick(3);
        stim.delete();
        for (int n = 0; n < 800; n++) stim.push_back(sine(n));
        first = find_first(stim);
        foreach (stim[i]) begin
            drive_sample(stim[i]);
            if (i == 400) check("sine_busy_in_capt", int'(busy), 1);
        end
        tick(3);
        check_capture("sine", stim, first);
        check("sine_done_cnt", done_cnt, 1);
        check("sine_done_after_last_write", done_cyc - last_wt_cyc, 1);
        for (int n = 800; n < 800 + HOLDOFF_TB + 150; n++) drive_sample(sine(n));
        hold_w = 0; post_w = 0;
        foreach (tq[i]) begin
            if (tq[i].cyc > done_cyc && tq[i].cyc <= done_cyc + HOLDOFF_TB - 1) hold_w++;
            if (tq[i].cyc > done_cyc + HOLDOFF_TB - 1) post_w++;
        end
        check("sine_writes_in_holdoff", hold_w, 0);
        check("sine_recapture_after_hold", int'(post_w > 0), 1);

        // Scaling table followed by random samples
        fresh_start();
        stim.delete();
        stim.push_back(-1000);
        foreach (ttab[k]) stim.push_back(ttab[k].s);
        for (int i = 0; i < TLEN; i++) begin
            r16 = 16'($urandom);
            stim.push_back(int'($signed(r16)));
        end
        first = find_first(stim);
        foreach (stim[i]) drive_sample(stim[i]);
        tick(3);
        check_capture("scale", stim, first);
        foreach (ttab[k]) begin
            w = (k < tq.size()) ? tq[k] : '{-1, -999, -1};
            check($sformatf("scale_tab_%0d_in_%0d", k, ttab[k].s), w.data, ttab[k].exp);
        end

        // Forced capture after the trigger timeout
        fresh_start();
        stim.delete();
        for (int i = 0; i < TIMEOUT + TLEN; i++) stim.push_back(100);
        first = find_first(stim);
        for (int i = 0; i < TIMEOUT + TLEN - 1; i++) drive_sample(100);
        tick(2);
        check("timeout_writes_before_last", tq.size(), TLEN - 1);
        drive_sample(100);
        tick(2);
        check_capture("timeout", stim, first);
        check("timeout_done_cnt", done_cnt, 1);

        // FFT frames
        fq.delete(); mags.delete();
        for (int b = 0; b < 256; b++) mags.push_back(b * 40);
        foreach (mags[b]) fft_beat(mags[b], b == 255);
        tick(2);
        check_freq("fft_ramp", mags);
        foreach (ftab[k]) begin
            w = (ftab[k].bin < fq.size()) ? fq[ftab[k].bin] : '{-1, -999, -1};
            check($sformatf("fft_tab_bin_%0d", ftab[k].bin), w.data, ftab[k].exp);
        end
        fq.delete(); mags.delete();
        for (int b = 0; b < 150; b++) mags.push_back(int'($urandom_range(0, 65535)));
        foreach (mags[b]) fft_beat(mags[b], b == 149);
        tick(2);
        check_freq("fft_random", mags);
        fq.delete(); mags.delete();
        mags.push_back(1000);
        fft_beat(1000, 1'b1);
        tick(2);
        check_freq("fft_single_beat", mags);
        fq.delete();
        enable = 1'b0;
        fft_beat(500, 1'b0);
        enable = 1'b1;
        for (int b = 1; b < 10; b++) fft_beat(800, b == 9);
        tick(2);
        check("fft_rejected_frame_writes", fq.size(), 0);
        fq.delete(); mags.delete();
        mags = '{160, 320, 4095};
        foreach (mags[b]) fft_beat(mags[b], b == 2);
        tick(2);
        check_freq("fft_after_reject", mags);

        // enable dropped at write index 300
        fresh_start();
        stim.delete();
        for (int n = 0; n < 800; n++) stim.push_back(sine(n));
        first = find_first(stim);
        foreach (stim[i]) begin
            if (enable && tq.size() >= 300) enable = 1'b0;
            drive_sample(stim[i]);
        end
        for (int n = 800; n < 800 + HOLDOFF_TB + 100; n++) drive_sample(sine(n));
        tick(2);
        check_capture("endrop", stim, first);
        check("endrop_done_cnt", done_cnt, 1);
        check("endrop_busy_fall_after_hold", busy_fall_cyc - done_cyc, HOLDOFF_TB - 1);
        check("endrop_busy_idle", int'(busy), 0);
        fq.delete();
        for (int b = 0; b < 20; b++) fft_beat(b * 100, b == 19);
        tick(2);
        check("endrop_fft_writes", fq.size(), 0);

        // Reset asserted at write index 200
        fresh_start();
        stim.delete();
        for (int n = 0; n < 800; n++) stim.push_back(sine(n));
        did_rst = 1'b0;
        foreach (stim[i]) begin
            if (!did_rst && tq.size() >= 200) begin
                resetN = 1'b0;
                #1;
                check("midrst_weaTime", int'(weaTime), 0);
                check("midrst_enaTime", int'(enaTime), 0);
                check("midrst_addraTime", int'(addraTime), 0);
                check("midrst_dinaTime", int'(dinaTime), 0);
                check("midrst_busy", int'(busy), 0);
                tick(2);
                resetN = 1'b1;
                tick(3);
                tq.delete();
                done_cnt = 0;
                did_rst = 1'b1;
                break;
            end
            drive_sample(stim[i]);
        end
        check("midrst_reached", int'(did_rst), 1);
        first = find_first(stim);
        foreach (stim[i]) drive_sample(stim[i]);
        tick(3);
        w = (tq.size() > 0) ? tq[0] : '{-1, -999, -1};
        check("midrst_restart_addr0", w.addr, 0);
        check_capture("midrst_restart", stim, first);
        check("midrst_done_cnt", done_cnt, 1);

        check("ena_equals_wea", ena_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
